coin_credit_fsm: RTL and testbench

//  Credit-accumulation state machine for the quarter-based vending front end.
//  - Takes raw coin and cancel push-buttons, synchronises and debounces them,
//    and accumulates credit in 25-cent steps.
//  - Drives the 4-bit state code that feeds the downstream 4-to-16 credit-display

---
 rtl/coin_pkg.sv | 35 +++
 rtl/btn_sync_debounce.sv | 52 +++++
 rtl/coin_credit_fsm.sv | 103 ++++++++++
 tb/tb_coin_credit_fsm.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared state encoding for the coin credit front end
// Purpose: state enum whose codes drive the credit-display decoder directly
//   (5=0.00, 6=0.25, 7=0.50, 8=0.75, 9=VEND), plus small credit helpers.
// Ports: none (package).
package coin_pkg;

  typedef enum logic [3:0] {
    S0   = 4'd5,
    S25  = 4'd6,
    S50  = 4'd7,
    S75  = 4'd8,
    VEND = 4'd9
  } coin_state_t;

  // Quarters held in a credit state; VEND and illegal codes report 0.
  function automatic logic [1:0] credit_of(input coin_state_t st);
    case (st)
      S25:     credit_of = 2'd1;
      S50:     credit_of = 2'd2;
      S75:     credit_of = 2'd3;
      default: credit_of = 2'd0;
    endcase
  endfunction

  // State reached from a credit state after one accepted coin.
  function automatic coin_state_t next_on_coin(input coin_state_t st);
    case (st)
      S0:      next_on_coin = S25;
      S25:     next_on_coin = S50;
      S50:     next_on_coin = S75;
      default: next_on_coin = VEND;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// rtl/btn_sync_debounce.sv - synchroniser, debouncer and rising-edge pulser
// Purpose: condition one raw, bouncy, asynchronous push-button.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   raw    in  raw button level, asynchronous to clk
//   pulse  out registered one-cycle pulse on each accepted press
module btn_sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          filt;
  logic          filt_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      filt   <= 1'b0;
      filt_d <= 1'b0;
      pulse  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      filt_d <= filt;
      pulse  <= filt & ~filt_d;
      // The counter only advances while the synchronised level disagrees with
      // the filtered level; the DEBOUNCE_CYCLES-th disagreeing cycle flips it.
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/coin_credit_fsm.sv
// rtl/coin_credit_fsm.sv - quarter credit accumulation FSM with vend and refund
// Purpose: accumulate credit from debounced coin presses, vend at 1.00,
//   refund on cancel.
// Ports:
//   clk              in  system clock
//   rst              in  asynchronous active-high reset
//   coin_in          in  raw coin button
//   cancel_in        in  raw cancel button
//   state_code       out credit state code to the display decoder (5..9)
//   vend             out high for the whole of state VEND
//   refund_valid     out one-cycle pulse when a cancel is accepted
//   refund_quarters  out quarters refunded, valid with refund_valid
//   reject           out one-cycle pulse when a coin arrives during VEND
module coin_credit_fsm
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int VEND_CYCLES     = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_in,
  input  logic       cancel_in,
  output logic [3:0] state_code,
  output logic       vend,
  output logic       refund_valid,
  output logic [1:0] refund_quarters,
  output logic       reject
);

  localparam int VW = $clog2(VEND_CYCLES + 1);
  localparam logic [VW-1:0] VEND_LAST = VW'(VEND_CYCLES - 1);

  logic          coin_p;
  logic          cancel_p;
  coin_state_t   state;
  logic [VW-1:0] vcnt;

  btn_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin (
    .clk   (clk),
    .rst   (rst),
    .raw   (coin_in),
    .pulse (coin_p)
  );

  btn_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
    .clk   (clk),
    .rst   (rst),
    .raw   (cancel_in),
    .pulse (cancel_p)
  );

  assign state_code = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S0;
      vend            <= 1'b0;
      vcnt            <= '0;
      refund_valid    <= 1'b0;
      refund_quarters <= 2'd0;
      reject          <= 1'b0;
    end else begin
      refund_valid    <= 1'b0;
      refund_quarters <= 2'd0;
      reject          <= 1'b0;
      case (state)
        S0, S25, S50, S75: begin
          // Cancel has priority: a simultaneous coin is simply dropped.
          if (cancel_p) begin
            state           <= S0;
            refund_valid    <= 1'b1;
            refund_quarters <= credit_of(state);
          end else if (coin_p) begin
            state <= next_on_coin(state);
            if (state == S75) begin
              vend <= 1'b1;
              vcnt <= '0;
            end
          end
        end
        VEND: begin
          if (coin_p) begin
            reject <= 1'b1;
          end
          if (vcnt == VEND_LAST) begin
            state <= S0;
            vend  <= 1'b0;
            vcnt  <= '0;
          end else begin
            vcnt <= vcnt + VW'(1);
          end
        end
        default: begin
          state <= S0;
          vend  <= 1'b0;
          vcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_credit_fsm.sv
// tb/tb_coin_credit_fsm.sv - self-checking bench for coin_credit_fsm
module tb_coin_credit_fsm;

  localparam int D     = 4;
  localparam int V     = 8;
  localparam int LAT   = 2 + D + 1;
  localparam int NEVT  = 8192;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       coin_in   = 1'b0;
  logic       cancel_in = 1'b0;
  logic [3:0] state_code;
  logic       vend;
  logic       refund_valid;
  logic [1:0] refund_quarters;
  logic       reject;

  bit run_clk = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: credit in quarters (4 means vending) and remaining vend time.
  bit coin_evt   [NEVT];
  bit cancel_evt [NEVT];
  int credit    = 0;
  int vend_left = 0;
  int e_rv      = 0;
  int e_rq      = 0;
  int e_rej     = 0;

  coin_credit_fsm #(
    .DEBOUNCE_CYCLES (D),
    .VEND_CYCLES     (V)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .coin_in         (coin_in),
    .cancel_in       (cancel_in),
    .state_code      (state_code),
    .vend            (vend),
    .refund_valid    (refund_valid),
    .refund_quarters (refund_quarters),
    .reject          (reject)
  );

  always begin
    #5;
    if (run_clk) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state_code", {28'd0, state_code}, 32'(5 + credit));
    chk("vend", {31'd0, vend}, (credit == 4) ? 32'd1 : 32'd0);
    chk("refund_valid", {31'd0, refund_valid}, 32'(e_rv));
    chk("refund_quarters", {30'd0, refund_quarters}, 32'(e_rq));
    chk("reject", {31'd0, reject}, 32'(e_rej));
  endtask

  task automatic clear_events();
    for (int i = 0; i < NEVT; i++) begin
      coin_evt[i]   = 1'b0;
      cancel_evt[i] = 1'b0;
    end
  endtask

  // Apply whatever accepted presses land on this edge.
  task automatic model_edge();
    bit cp;
    bit kp;
    e_rv  = 0;
    e_rq  = 0;
    e_rej = 0;
    if (rst) begin
      credit    = 0;
      vend_left = 0;
      return;
    end
    cp = (cyc < NEVT) ? coin_evt[cyc] : 1'b0;
    kp = (cyc < NEVT) ? cancel_evt[cyc] : 1'b0;
    if (credit == 4) begin
      if (cp) e_rej = 1;
      vend_left--;
      if (vend_left == 0) credit = 0;
    end else if (kp) begin
      e_rv   = 1;
      e_rq   = credit;
      credit = 0;
    end else if (cp) begin
      credit++;
      if (credit == 4) vend_left = V;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    model_edge();
    check_all();
  endtask

  task automatic schedule(input bit c, input bit k);
    int at;
    at = cyc + 1 + LAT;
    if (at < NEVT) begin
      if (c) coin_evt[at] = 1'b1;
      if (k) cancel_evt[at] = 1'b1;
    end
  endtask

  task automatic press(input bit c, input bit k, input int h, input int l);
    schedule(c, k);
    coin_in   = c;
    cancel_in = k;
    repeat (h) step();
    coin_in   = 1'b0;
    cancel_in = 1'b0;
    repeat (l) step();
  endtask

  initial begin
    clear_events();

    // 1: reset with no clock running
    #1 rst = 1'b1;
    #1;
    check_all();
    rst = 1'b0;
    #1 run_clk = 1'b1;
    repeat (3) step();

    // 2: four clean presses up to VEND and back
    repeat (4) press(1'b1, 1'b0, 10, 10);
    repeat (5) step();

    // 3: bouncing coin never stable long enough, then a clean hold
    for (int i = 0; i < 5; i++) begin
      coin_in = 1'b1;
      repeat (2) step();
      coin_in = 1'b0;
      repeat (2) step();
    end
    press(1'b1, 1'b0, 10, 10);

    // 4: back to S0, two coins, cancel, then cancel again in S0
    press(1'b0, 1'b1, 6, 6);
    press(1'b1, 1'b0, 6, 6);
    press(1'b1, 1'b0, 6, 6);
    press(1'b0, 1'b1, 6, 6);
    press(1'b0, 1'b1, 6, 6);

    // 5: tightest coin spacing, fifth coin arrives while vending
    repeat (4) press(1'b1, 1'b0, D, D);
    press(1'b1, 1'b0, D, 12);

    // 6: coin and cancel together in S50
    press(1'b1, 1'b0, 6, 6);
    press(1'b1, 1'b0, 6, 6);
    press(1'b1, 1'b1, 6, 6);

    // 7: reset in the middle of VEND
    repeat (3) press(1'b1, 1'b0, 5, 5);
    press(1'b1, 1'b0, 5, 5);
    rst = 1'b1;
    #1;
    credit = 0;
    e_rv   = 0;
    e_rq   = 0;
    e_rej  = 0;
    check_all();
    clear_events();
    repeat (2) step();
    rst = 1'b0;
    press(1'b1, 1'b0, 6, 6);

    // randomized presses against the model
    for (int n = 0; n < 40; n++) begin
      int r;
      bit c;
      bit k;
      r = int'($urandom_range(0, 9));
      c = (r < 6) || (r >= 8);
      k = (r >= 6);
      press(c, k, int'($urandom_range(D, D + 5)), int'($urandom_range(D, D + 5)));
    end
    repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
